// File: rtl/muldiv_seq.sv
// Multicycle signed MULT/DIV sequencer: radix-2 Booth multiplier and restoring
// divider sharing a start/done handshake, owning the HI/LO result registers.
module muldiv_seq #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic [1:0]        state_dbg
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    // Handshake: start is sampled only in IDLE (start while busy is dropped);
    // done is a one-cycle pulse in FIN with hi_out/lo_out already valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]  cnt;
    logic              last_step;
    logic              accept_mult;
    logic              accept_div;
    logic              accept_dz;

    // Booth datapath
    logic [DATA_W:0]   acc;
    logic [DATA_W-1:0] mplr;
    logic              q_m1;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W:0]   mcand_x;
    logic [DATA_W:0]   booth_sum;
    logic [DATA_W:0]   acc_n;
    logic [DATA_W-1:0] mplr_n;

    // Restoring divider datapath (magnitudes only, signs applied at the end)
    logic [DATA_W:0]   rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dvsr;
    logic              q_neg;
    logic              r_neg;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W:0]   trial;
    logic [DATA_W:0]   rem_n;
    logic [DATA_W-1:0] quo_n;
    logic [DATA_W-1:0] q_fin;
    logic [DATA_W-1:0] r_fin;

    logic [DATA_W-1:0] a_abs;
    logic [DATA_W-1:0] b_abs;

    assign state_dbg   = state;
    assign last_step   = (cnt == CNT_LAST);
    assign accept_mult = (state == IDLE) && start && !op;
    assign accept_div  = (state == IDLE) && start && op && (b_in != '0);
    assign accept_dz   = (state == IDLE) && start && op && (b_in == '0);
    assign a_abs       = a_in[DATA_W-1] ? -a_in : a_in;
    assign b_abs       = b_in[DATA_W-1] ? -b_in : b_in;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_mult)     state_next = MULT;
                else if (accept_div) state_next = DIV;
                else if (accept_dz)  state_next = FIN;
            end
            MULT:    if (last_step) state_next = FIN;
            DIV:     if (last_step) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // One Booth step: add/subtract on the extended accumulator, then an
    // arithmetic shift of {acc, mplr, q_m1}. The extra acc bit keeps
    // subtracting the most negative multiplicand from overflowing.
    always_comb begin
        mcand_x = {mcand[DATA_W-1], mcand};
        case ({mplr[0], q_m1})
            2'b01:   booth_sum = acc + mcand_x;
            2'b10:   booth_sum = acc - mcand_x;
            default: booth_sum = acc;
        endcase
        acc_n  = {booth_sum[DATA_W], booth_sum[DATA_W:1]};
        mplr_n = {booth_sum[0], mplr[DATA_W-1:1]};
    end

    // One restoring step: shift the next dividend bit in, keep the trial
    // difference only when it did not go negative.
    always_comb begin
        rem_sh = {rem[DATA_W-1:0], quo[DATA_W-1]};
        trial  = rem_sh - {1'b0, dvsr};
        rem_n  = trial[DATA_W] ? rem_sh : trial;
        quo_n  = {quo[DATA_W-2:0], ~trial[DATA_W]};
        q_fin  = q_neg ? -quo_n : quo_n;
        r_fin  = r_neg ? -rem_n[DATA_W-1:0] : rem_n[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            acc      <= '0;
            mplr     <= '0;
            q_m1     <= 1'b0;
            mcand    <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
        end else begin
            busy     <= (state_next != IDLE);
            done     <= (state_next == FIN);
            div_zero <= accept_dz;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept_mult) begin
                        acc   <= '0;
                        mplr  <= b_in;
                        q_m1  <= 1'b0;
                        mcand <= a_in;
                    end
                    if (accept_div) begin
                        rem   <= '0;
                        quo   <= a_abs;
                        dvsr  <= b_abs;
                        q_neg <= a_in[DATA_W-1] ^ b_in[DATA_W-1];
                        r_neg <= a_in[DATA_W-1];
                    end
                end
                MULT: begin
                    acc  <= acc_n;
                    mplr <= mplr_n;
                    q_m1 <= mplr[0];
                    cnt  <= cnt + CNT_W'(1);
                    if (last_step) begin
                        hi_out <= acc_n[DATA_W-1:0];
                        lo_out <= mplr_n;
                    end
                end
                DIV: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    cnt <= cnt + CNT_W'(1);
                    if (last_step) begin
                        hi_out <= r_fin;
                        lo_out <= q_fin;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule
